// File: rtl/transmit_buffer_if.sv
// Avalon-MM port the PCIe side uses to fill transmit slots and read slot occupancy.
interface transmit_buffer_if;
  logic [9:0]   address;
  logic         chipselect;
  logic         write;
  logic [255:0] writedata;
  logic [31:0]  byteenable;
  logic [255:0] readdata;
  logic         waitrequest;

  modport master (
    output address, chipselect, write, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/transmit_buffer.sv
// Sixteen 256-bit slot FIFOs filled over PCIe and drained by the Rdma engine,
// plus the buffer pool register/release bookkeeping that relocates the slot window.
module transmit_buffer #(
  parameter int SLOT_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  transmit_buffer_if.slave bus,
  input  logic [3:0]       QN,
  input  logic             pop,
  output logic [255:0]     popData,
  output logic             popValid,
  output logic             popError,
  output logic [15:0]      slotReady,
  input  logic             bufRegister,
  input  logic [2:0]       rgstrNum,
  input  logic             bufRelease,
  input  logic             freshMapping,
  output logic [4:0]       rgstrPtr,
  output logic [4:0]       lastNum,
  output logic             poolFull,
  output logic             poolEmpty
);
  localparam int PTR_W = (SLOT_DEPTH > 1) ? $clog2(SLOT_DEPTH) : 1;
  localparam int OCC_W = $clog2(SLOT_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(SLOT_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SLOT_DEPTH - 1);

  function automatic logic [255:0] maskBytes(input logic [255:0] data, input logic [31:0] be);
    logic [255:0] m;
    m = {256{1'b0}};
    for (int b = 0; b < 32; b++) begin
      m[b*8 +: 8] = be[b] ? data[b*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

  function automatic logic [3:0] clipOcc(input logic [OCC_W-1:0] occ);
    logic [31:0] wide;
    wide = 32'(occ);
    return (wide > 32'd15) ? 4'hF : wide[3:0];
  endfunction

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [OCC_W-1:0] occ_r   [16];
  logic [PTR_W-1:0] wrPtr_r [16];
  logic [PTR_W-1:0] rdPtr_r [16];
  logic [255:0]     mem_r   [16][SLOT_DEPTH];

  logic [3:0]   basePtr_r;
  logic [4:0]   registerPtr_r;
  logic [4:0]   releasePtr_r;
  logic [4:0]   lastNum_r;
  logic [255:0] readData_r;
  logic [255:0] popData_r;
  logic         popValid_r;
  logic         popError_r;

  logic [3:0]  realPtr_s;
  logic [15:0] full_s;
  logic [15:0] empty_s;
  logic [15:0] slotWr_s;
  logic [15:0] slotRd_s;
  logic        wrEn_s;
  logic        rdEn_s;
  logic        popHit_s;
  logic        popMiss_s;
  logic        regOk_s;
  logic        relOk_s;
  logic [4:0]  lastNumNext_s;
  logic        unusedAddrBits_s;

  // Slot decode, per-slot status and write/pop qualification.
  always_comb begin
    realPtr_s = basePtr_r + bus.address[6:3];
    for (int i = 0; i < 16; i++) begin
      full_s[i]  = (occ_r[i] == OCC_FULL);
      empty_s[i] = (occ_r[i] == {OCC_W{1'b0}});
    end
    wrEn_s    = bus.chipselect & bus.write & ~full_s[realPtr_s];
    rdEn_s    = bus.chipselect & ~bus.write;
    popHit_s  = pop & ~empty_s[QN];
    popMiss_s = pop & empty_s[QN];
    for (int i = 0; i < 16; i++) begin
      slotWr_s[i] = wrEn_s & (realPtr_s == 4'(i));
      slotRd_s[i] = popHit_s & (QN == 4'(i));
    end
  end

  // Pool acceptance: register checked against the pre-release count; release saturates at 16.
  always_comb begin
    regOk_s       = bufRegister & ({2'b00, rgstrNum} <= lastNum_r);
    relOk_s       = bufRelease & (lastNum_r != 5'd16);
    lastNumNext_s = lastNum_r - (regOk_s ? {2'b00, rgstrNum} : 5'd0) + (relOk_s ? 5'd1 : 5'd0);
  end

  // Per-slot occupancy and wrap-around FIFO pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        occ_r[i]   <= {OCC_W{1'b0}};
        wrPtr_r[i] <= {PTR_W{1'b0}};
        rdPtr_r[i] <= {PTR_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (slotWr_s[i]) wrPtr_r[i] <= nextPtr(wrPtr_r[i]);
        if (slotRd_s[i]) rdPtr_r[i] <= nextPtr(rdPtr_r[i]);
        if (slotWr_s[i] && !slotRd_s[i]) begin
          occ_r[i] <= occ_r[i] + OCC_W'(1);
        end else if (!slotWr_s[i] && slotRd_s[i]) begin
          occ_r[i] <= occ_r[i] - OCC_W'(1);
        end
      end
    end
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (wrEn_s) begin
      mem_r[realPtr_s][wrPtr_r[realPtr_s]] <= maskBytes(bus.writedata, bus.byteenable);
    end
  end

  // Rdma return path and registered occupancy readback.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      popData_r  <= {256{1'b0}};
      popValid_r <= 1'b0;
      popError_r <= 1'b0;
      readData_r <= {256{1'b0}};
    end else begin
      popValid_r <= popHit_s;
      popError_r <= popMiss_s;
      if (popHit_s) popData_r <= mem_r[QN][rdPtr_r[QN]];
      if (rdEn_s) readData_r <= {252'd0, clipOcc(occ_r[realPtr_s])};
    end
  end

  // Pool pointers and the slot window base.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      registerPtr_r <= 5'd0;
      releasePtr_r  <= 5'd0;
      lastNum_r     <= 5'd16;
      basePtr_r     <= 4'd0;
    end else begin
      if (regOk_s) registerPtr_r <= registerPtr_r + {2'b00, rgstrNum};
      if (relOk_s) releasePtr_r <= releasePtr_r + 5'd1;
      lastNum_r <= lastNumNext_s;
      if (freshMapping) basePtr_r <= releasePtr_r[3:0];
    end
  end

  assign unusedAddrBits_s = ^{bus.address[9:7], bus.address[2:0]};

  assign bus.waitrequest = bus.chipselect & bus.write & full_s[realPtr_s];
  assign bus.readdata    = readData_r;
  assign popData         = popData_r;
  assign popValid        = popValid_r;
  assign popError        = popError_r;
  assign slotReady       = ~empty_s;
  assign rgstrPtr        = registerPtr_r;
  assign lastNum         = lastNum_r;
  assign poolEmpty       = (registerPtr_r == releasePtr_r);
  assign poolFull        = (registerPtr_r[3:0] == releasePtr_r[3:0]) &
                           (registerPtr_r[4] != releasePtr_r[4]);
endmodule

// File: tb/tb_transmit_buffer.sv
// Directed bench for transmit_buffer: pop data checked against a scoreboard queue
// filled as writes are driven; status outputs checked against hand-derived values.
module tb_transmit_buffer;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   QN;
  logic         pop;
  logic [255:0] popData;
  logic         popValid;
  logic         popError;
  logic [15:0]  slotReady;
  logic         bufRegister;
  logic [2:0]   rgstrNum;
  logic         bufRelease;
  logic         freshMapping;
  logic [4:0]   rgstrPtr;
  logic [4:0]   lastNum;
  logic         poolFull;
  logic         poolEmpty;

  transmit_buffer_if bus();

  transmit_buffer #(.SLOT_DEPTH(8)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave),
    .QN(QN), .pop(pop), .popData(popData), .popValid(popValid), .popError(popError),
    .slotReady(slotReady), .bufRegister(bufRegister), .rgstrNum(rgstrNum),
    .bufRelease(bufRelease), .freshMapping(freshMapping), .rgstrPtr(rgstrPtr),
    .lastNum(lastNum), .poolFull(poolFull), .poolEmpty(poolEmpty)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int failures = 0;
  logic [255:0] sbq[$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic popCheck(input string tag);
    logic [255:0] exp;
    tests++;
    assert (sbq.size() != 0) else begin
      failures++;
      $error("FAIL %s: observed pop with empty scoreboard expected queued entry", tag);
    end
    if (sbq.size() != 0) begin
      exp = sbq.pop_front();
      check({tag, "_valid"}, 256'(popValid), 256'd1);
      check({tag, "_data"}, popData, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idleBus();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic drvWrite(input logic [9:0] a, input logic [255:0] d, input logic [31:0] be);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.writedata  = d;
    bus.byteenable = be;
  endtask

  task automatic drvRead(input logic [9:0] a);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
  endtask

  function automatic logic [255:0] pat(input int n);
    return {8{32'hC0DE0000 | 32'(n)}};
  endfunction

  initial begin
    QN = 4'd0; pop = 1'b0; bufRegister = 1'b0; rgstrNum = 3'd0;
    bufRelease = 1'b0; freshMapping = 1'b0;
    bus.address = 10'd0; bus.chipselect = 1'b0; bus.write = 1'b0;
    bus.writedata = 256'd0; bus.byteenable = 32'd0;

    // Held in reset, with a write strobe present
    tick(); tick();
    drvWrite(10'h000, pat(99), 32'hFFFFFFFF); settle();
    check("rst_waitrequest", 256'(bus.waitrequest), 256'd0);
    check("rst_readdata", bus.readdata, 256'd0);
    check("rst_popData", popData, 256'd0);
    check("rst_popValid", 256'(popValid), 256'd0);
    check("rst_popError", 256'(popError), 256'd0);
    check("rst_slotReady", 256'(slotReady), 256'd0);
    check("rst_poolEmpty", 256'(poolEmpty), 256'd1);
    check("rst_poolFull", 256'(poolFull), 256'd0);
    check("rst_lastNum", 256'(lastNum), 256'd16);
    check("rst_rgstrPtr", 256'(rgstrPtr), 256'd0);
    idleBus(); reset = 1'b1; tick();

    // Fill slot 0, stall the ninth write, release it with a pop
    for (int i = 0; i < 8; i++) begin
      drvWrite(10'h000, pat(i), 32'hFFFFFFFF); settle();
      check($sformatf("fill_wait%0d", i), 256'(bus.waitrequest), 256'd0);
      sbq.push_back(pat(i));
      tick();
    end
    drvWrite(10'h000, pat(8), 32'hFFFFFFFF); settle();
    check("fill_full_wait", 256'(bus.waitrequest), 256'd1);
    check("fill_slotReady", 256'(slotReady), 256'h1);
    tick();
    check("fill_hold_wait", 256'(bus.waitrequest), 256'd1);
    QN = 4'd0; pop = 1'b1; tick(); pop = 1'b0;
    popCheck("fill_pop");
    settle();
    check("fill_unstall", 256'(bus.waitrequest), 256'd0);
    sbq.push_back(pat(8));
    tick(); idleBus();
    drvRead(10'h000); tick(); idleBus();
    check("fill_occ", bus.readdata, 256'd8);
    pop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) pop = 1'b0;
      popCheck($sformatf("drain%0d", i));
    end
    check("drain_slotReady", 256'(slotReady), 256'd0);

    // Byte enables and FIFO order
    drvWrite(10'h000, {32{8'hAA}}, 32'h0000FFFF); tick();
    sbq.push_back({128'd0, {16{8'hAA}}});
    drvWrite(10'h000, {32{8'hBB}}, 32'hFFFFFFFF); tick();
    sbq.push_back({32{8'hBB}});
    idleBus();
    QN = 4'd0; pop = 1'b1; tick();
    popCheck("be_pop0");
    tick(); pop = 1'b0;
    popCheck("be_pop1");
    tick();
    check("be_valid_once", 256'(popValid), 256'd0);

    // Underrun on an empty slot
    QN = 4'd5; pop = 1'b1; tick(); pop = 1'b0;
    check("under_error", 256'(popError), 256'd1);
    check("under_valid", 256'(popValid), 256'd0);
    check("under_data", popData, {32{8'hBB}});
    tick();
    check("under_error_once", 256'(popError), 256'd0);

    // Write and pop together: empty slot then non-empty slot
    drvWrite(10'h018, pat(30), 32'hFFFFFFFF); QN = 4'd3; pop = 1'b1; tick();
    pop = 1'b0; idleBus();
    check("empty_wp_error", 256'(popError), 256'd1);
    check("empty_wp_valid", 256'(popValid), 256'd0);
    check("empty_wp_ready", 256'(slotReady), 256'h8);
    sbq.push_back(pat(30));
    drvWrite(10'h018, pat(31), 32'hFFFFFFFF); pop = 1'b1; tick();
    pop = 1'b0; idleBus();
    sbq.push_back(pat(31));
    popCheck("same_wp_pop");
    drvRead(10'h018); tick(); idleBus();
    check("same_wp_occ", bus.readdata, 256'd1);
    pop = 1'b1; tick(); pop = 1'b0;
    popCheck("same_wp_pop2");
    check("same_wp_ready", 256'(slotReady), 256'd0);

    // Remap the window through the pool pointers
    bufRegister = 1'b1; rgstrNum = 3'd3; tick(); bufRegister = 1'b0;
    check("map_rgstrPtr", 256'(rgstrPtr), 256'd3);
    check("map_lastNum13", 256'(lastNum), 256'd13);
    check("map_notEmpty", 256'(poolEmpty), 256'd0);
    bufRelease = 1'b1; tick(); tick(); tick(); bufRelease = 1'b0;
    check("map_lastNum16", 256'(lastNum), 256'd16);
    check("map_poolEmpty", 256'(poolEmpty), 256'd1);
    freshMapping = 1'b1; tick(); freshMapping = 1'b0;
    drvWrite(10'h008, pat(40), 32'hFFFFFFFF); tick(); idleBus();
    sbq.push_back(pat(40));
    check("map_slot4", 256'(slotReady), 256'h10);
    drvRead(10'h008); tick(); idleBus();
    check("map_occ", bus.readdata, 256'd1);
    QN = 4'd4; pop = 1'b1; tick(); pop = 1'b0;
    popCheck("map_pop");

    // Reset in the middle of filling slot 2 (offset 15 with base 3)
    bufRegister = 1'b1; rgstrNum = 3'd5; tick(); bufRegister = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drvWrite(10'h078, pat(50 + i), 32'hFFFFFFFF); tick();
    end
    idleBus();
    check("mid_slotReady", 256'(slotReady), 256'h4);
    check("mid_lastNum", 256'(lastNum), 256'd11);
    reset = 1'b0; settle();
    check("mid_rst_ready", 256'(slotReady), 256'd0);
    check("mid_rst_lastNum", 256'(lastNum), 256'd16);
    check("mid_rst_poolEmpty", 256'(poolEmpty), 256'd1);
    tick(); reset = 1'b1; tick();
    check("post_rst_ready", 256'(slotReady), 256'd0);
    QN = 4'd2; pop = 1'b1; tick(); pop = 1'b0;
    check("post_rst_popError", 256'(popError), 256'd1);
    drvWrite(10'h010, pat(60), 32'hFFFFFFFF); tick(); idleBus();
    check("post_rst_base0", 256'(slotReady), 256'h4);

    // Pool accounting limits
    bufRelease = 1'b1; tick(); bufRelease = 1'b0;
    check("pool_rel_at16", 256'(lastNum), 256'd16);
    check("pool_rel_at16_empty", 256'(poolEmpty), 256'd1);
    bufRegister = 1'b1; rgstrNum = 3'd7; tick(); tick(); bufRegister = 1'b0;
    check("pool_reg77_last", 256'(lastNum), 256'd2);
    check("pool_reg77_ptr", 256'(rgstrPtr), 256'd14);
    bufRegister = 1'b1; rgstrNum = 3'd3; tick(); bufRegister = 1'b0;
    check("pool_reg3_ignored_last", 256'(lastNum), 256'd2);
    check("pool_reg3_ignored_ptr", 256'(rgstrPtr), 256'd14);
    bufRegister = 1'b1; rgstrNum = 3'd2; bufRelease = 1'b1; tick();
    bufRegister = 1'b0; bufRelease = 1'b0;
    check("pool_both_last", 256'(lastNum), 256'd1);
    check("pool_both_ptr", 256'(rgstrPtr), 256'd16);
    check("pool_both_full", 256'(poolFull), 256'd0);
    bufRegister = 1'b1; rgstrNum = 3'd1; tick(); bufRegister = 1'b0;
    check("pool_full", 256'(poolFull), 256'd1);
    check("pool_full_last", 256'(lastNum), 256'd0);
    bufRegister = 1'b1; rgstrNum = 3'd1; tick(); bufRegister = 1'b0;
    check("pool_reg_at0", 256'(rgstrPtr), 256'd17);
    check("pool_full_notEmpty", 256'(poolEmpty), 256'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/transmit_buffer.md
TRANSMIT_BUFFER -- requirements
Module: transmit_buffer

Interface
REQ-001 SHALL have parameter SLOT_DEPTH, default 8, meaning entries per slot FIFO (256-bit each); 16 slots fixed.
REQ-002 SHALL have port clock  input  1  single clock for all logic.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  10  PCIe Avalon-MM address; address[6:3] = slot offset.
REQ-005 SHALL have ports chipselect, write  input  1 each  PCIe access strobes.
REQ-006 SHALL have ports writedata  input  256  and byteenable  input  32  PCIe write data and byte lanes.
REQ-007 SHALL have port readdata  output  256  registered occupancy readback.
REQ-008 SHALL have port waitrequest  output  1  PCIe stall.
REQ-009 SHALL have ports QN  input  4  and pop  input  1  Rdma slot select and pop request.
REQ-010 SHALL have ports popData  output  256,  popValid  output  1,  popError  output  1  Rdma data return.
REQ-011 SHALL have port slotReady  output  16  per-slot non-empty flags.
REQ-012 SHALL have ports bufRegister  input  1,  rgstrNum  input  3,  bufRelease  input  1,  freshMapping  input  1  pool control.
REQ-013 SHALL have ports rgstrPtr  output  5,  lastNum  output  5,  poolFull  output  1,  poolEmpty  output  1  pool status.

Function
REQ-014 Target slot SHALL be realPtr = (basePtr + address[6:3]) mod 16; basePtr SHALL load releasePtr[3:0] on the clock after freshMapping=1, else hold.
REQ-015 waitrequest SHALL equal combinational full flag of slot realPtr when chipselect&write, else 0.
REQ-016 A write SHALL be accepted when chipselect&write&~waitrequest; entry stored is writedata with bytes whose byteenable bit is 0 forced to 0x00.
REQ-017 A write to a full slot SHALL not be stored, regardless of a same-cycle pop on that slot.
REQ-018 Read (chipselect&~write) SHALL never stall; readdata SHALL update one cycle later to {252'd0, occupancy of realPtr[3:0] clipped to 4 bits}.
REQ-019 Pop with slot QN non-empty SHALL remove the oldest entry; popData SHALL present it the next cycle with popValid=1 for exactly one cycle.
REQ-020 Pop with slot QN empty SHALL remove nothing, keep popData, drive popValid=0 and popError=1 for one cycle.
REQ-021 Simultaneous accepted write and pop on the same non-empty slot SHALL both occur; occupancy unchanged; FIFO order preserved.
REQ-022 Simultaneous write and pop on an empty slot SHALL store the write and flag popError (no bypass).
REQ-023 Each slot SHALL keep occupancy 0..SLOT_DEPTH with wrap-around read/write pointers; slotReady[i] = occupancy_i != 0.
REQ-024 registerPtr SHALL advance by rgstrNum on bufRegister; releasePtr SHALL advance by 1 on bufRelease; both 5 bits, mod 32.
REQ-025 A bufRegister with rgstrNum > lastNum (pre-release value) SHALL be ignored entirely; a same-cycle release still applies.
REQ-026 lastNum SHALL update as lastNum - rgstrNum(if accepted) + bufRelease, range 0..16; bufRelease with lastNum=16 SHALL be ignored.
REQ-027 poolEmpty SHALL be (registerPtr == releasePtr); poolFull SHALL be (low 4 bits equal) & (bit 4 differs); rgstrPtr = registerPtr.

Reset
REQ-028 On reset low, all slot occupancies, FIFO pointers, registerPtr, releasePtr, basePtr SHALL clear to 0 immediately; lastNum=16.
REQ-029 During reset: readdata=0, popData=0, popValid=0, popError=0, slotReady=0, waitrequest=0, poolEmpty=1, poolFull=0.
REQ-030 Reset mid-operation SHALL discard all stored entries; first access after deassert SHALL see all slots empty.

Verification
REQ-031 Fill: 8 writes to address 0x000, then 9th -> waitrequest=1 held until Rdma pop QN=0; slotReady[0]=1.
REQ-032 Order/byteenable: write 0xA..A (byteenable=0x0000FFFF) then 0xB..B, pop QN=0 twice -> popData upper 16 bytes 0x00, lower 0xA..A, then 0xB..B, popValid each next cycle.
REQ-033 Underrun: pop QN=5 on empty slot -> popError=1 one cycle, popValid=0, popData unchanged.
REQ-034 Mapping: register 3 then release 3 then freshMapping, write address 0x008 -> lands in slot 4; readdata for address 0x008 read = 1.
REQ-035 Pool: register rgstrNum=7 twice, then rgstrNum=3 -> lastNum=2, third ignored; release+register(2) same cycle -> lastNum=1, rgstrPtr=16.
REQ-036 Reset mid-fill: 4 writes to slot 2, assert reset -> slotReady=0, lastNum=16, poolEmpty=1 after deassert.
